// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller lamp stage:
// light codes, fault codes, lamp patterns and the lamp FSM state enum.
package traffic_pkg;

  // 2-bit light codes produced by the controller
  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b10;
  localparam logic [1:0] LIGHT_INV = 2'b11;

  // Latched fault cause, first cause wins
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_CONFLICT = 2'b01;
  localparam logic [1:0] FLT_SEQ      = 2'b10;
  localparam logic [1:0] FLT_INVALID  = 2'b11;

  // Lamp enables, {red,yellow,green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'b00,
    ST_FAULT_ON  = 2'b01,
    ST_FAULT_OFF = 2'b10
  } lamp_state_e;

  // Light code to one-hot lamp pattern; the invalid code shows red
  function automatic logic [2:0] decode_light(input logic [1:0] code);
    logic [2:0] lamps;
    case (code)
      LIGHT_YEL: lamps = LAMP_YEL;
      LIGHT_GRN: lamps = LAMP_GRN;
      default:   lamps = LAMP_RED;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_seq_check.sv
// Per-approach legality check on one registered light-code sample:
// flags the invalid code and any prev->cur transition that is not
// "same", red->green, green->yellow or yellow->red.
module lamp_seq_check
  import traffic_pkg::*;
(
  input  logic [1:0] prev_i,
  input  logic [1:0] cur_i,
  output logic       invalid_o,
  output logic       illegal_o
);

  assign invalid_o = (cur_i == LIGHT_INV);

  // Whitelist of legal phase transitions; everything else is illegal
  always_comb begin
    illegal_o = 1'b1;
    if (prev_i == cur_i) begin
      illegal_o = 1'b0;
    end else begin
      case ({prev_i, cur_i})
        {LIGHT_RED, LIGHT_GRN},
        {LIGHT_GRN, LIGHT_YEL},
        {LIGHT_YEL, LIGHT_RED}: illegal_o = 1'b0;
        default:                illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver: registers the controller's light codes, checks them for
// conflicts, illegal sequences and invalid codes, and drives one-hot lamps.
// Any violation latches a fault and flashes red on both approaches until
// fault_clr is given while both approaches sample red.
// Optional macro LAMP_TEST_EN adds a lamp_test input that lights all lamps
// in NORMAL. dbg_state exposes the lamp FSM state.
// Handshake: none; inputs are sampled every cycle, outputs are valid every
// cycle, input-to-lamp latency is two clock edges.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int FLASH_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  main_light,
  input  logic [1:0]  side_light,
  input  logic        fault_clr,
`ifdef LAMP_TEST_EN
  input  logic        lamp_test,
`endif
  output logic [2:0]  main_rgy,
  output logic [2:0]  side_rgy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output lamp_state_e dbg_state
);

  localparam int CW = $clog2(FLASH_HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_HALF - 1);

  lamp_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_m_q, cur_m_d, cur_s_q, cur_s_d;
  logic [1:0]    prev_m_q, prev_m_d, prev_s_q, prev_s_d;
  logic [2:0]    main_q, main_d, side_q, side_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic inv_m, inv_s, ill_m, ill_s;
  logic [1:0] cause;
  logic clr_ok;

  lamp_seq_check u_chk_main (
    .prev_i    (prev_m_q),
    .cur_i     (cur_m_q),
    .invalid_o (inv_m),
    .illegal_o (ill_m)
  );

  lamp_seq_check u_chk_side (
    .prev_i    (prev_s_q),
    .cur_i     (cur_s_q),
    .invalid_o (inv_s),
    .illegal_o (ill_s)
  );

  // Fault cause on the current sample, invalid > conflict > sequence
  always_comb begin
    cause = FLT_NONE;
    if (inv_m || inv_s) begin
      cause = FLT_INVALID;
    end else if ((cur_m_q != LIGHT_RED) && (cur_s_q != LIGHT_RED)) begin
      cause = FLT_CONFLICT;
    end else if (ill_m || ill_s) begin
      cause = FLT_SEQ;
    end
  end

  assign clr_ok = fault_clr && (cur_m_q == LIGHT_RED) && (cur_s_q == LIGHT_RED);

  // Next-state, flash timing and registered lamp outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    main_d   = main_q;
    side_d   = side_q;
    fault_d  = fault_q;
    code_d   = code_q;
    cur_m_d  = main_light;
    cur_s_d  = side_light;
    prev_m_d = cur_m_q;
    prev_s_d = cur_s_q;
    case (state_q)
      ST_NORMAL: begin
        if (cause != FLT_NONE) begin
          // The violating sample is never displayed
          state_d = ST_FAULT_ON;
          fault_d = 1'b1;
          code_d  = cause;
          main_d  = LAMP_RED;
          side_d  = LAMP_RED;
          cnt_d   = '0;
        end else begin
          main_d = decode_light(cur_m_q);
          side_d = decode_light(cur_s_q);
`ifdef LAMP_TEST_EN
          if (lamp_test) begin
            main_d = LAMP_ALL;
            side_d = LAMP_ALL;
          end
`endif
        end
      end
      ST_FAULT_ON, ST_FAULT_OFF: begin
        if (clr_ok) begin
          // Clear wins over the flash toggle on the same edge
          state_d  = ST_NORMAL;
          fault_d  = 1'b0;
          code_d   = FLT_NONE;
          main_d   = LAMP_RED;
          side_d   = LAMP_RED;
          cnt_d    = '0;
          prev_m_d = LIGHT_RED;
          prev_s_d = LIGHT_RED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == ST_FAULT_ON) ? ST_FAULT_OFF : ST_FAULT_ON;
          main_d  = (state_q == ST_FAULT_ON) ? LAMP_OFF : LAMP_RED;
          side_d  = main_d;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          main_d = (state_q == ST_FAULT_ON) ? LAMP_RED : LAMP_OFF;
          side_d = main_d;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        main_d  = LAMP_RED;
        side_d  = LAMP_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sample registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      cnt_q    <= '0;
      cur_m_q  <= LIGHT_RED;
      cur_s_q  <= LIGHT_RED;
      prev_m_q <= LIGHT_RED;
      prev_s_q <= LIGHT_RED;
      main_q   <= LAMP_RED;
      side_q   <= LAMP_RED;
      fault_q  <= 1'b0;
      code_q   <= FLT_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_m_q  <= cur_m_d;
      cur_s_q  <= cur_s_d;
      prev_m_q <= prev_m_d;
      prev_s_q <= prev_s_d;
      main_q   <= main_d;
      side_q   <= side_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign main_rgy   = main_q;
  assign side_rgy   = side_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign dbg_state  = state_q;

endmodule
